// File: rtl/l2_memory_responder_if.sv
// Cache-to-backing-memory request bus, plus the memory operation type
// shared by the requester (icache) and the responder.
package xentry_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'b00,
    STORE = 2'b01
  } memory_operation_e;

endpackage

interface l2_memory_responder_if #(
  parameter int XLEN = 32
);
  import xentry_pkg::*;

  logic [XLEN-1:0]   l2_req_address;
  memory_operation_e l2_req_type;
  logic              l2_req_valid;
  logic [XLEN-1:0]   l2_word_to_store;
  logic [XLEN-1:0]   l2_fetched_word;
  logic              l2_req_fulfilled;
  logic              busy;

  modport master (
    output l2_req_address, l2_req_type, l2_req_valid, l2_word_to_store,
    input  l2_fetched_word, l2_req_fulfilled, busy
  );

  modport slave (
    input  l2_req_address, l2_req_type, l2_req_valid, l2_word_to_store,
    output l2_fetched_word, l2_req_fulfilled, busy
  );

endinterface

// File: rtl/l2_memory_responder.sv
// Word-addressed backing memory that answers LOAD/STORE requests after a
// fixed, per-type latency and signals completion with a one-cycle pulse.
module l2_memory_responder
  import xentry_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int MEM_SIZE      = 4096,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  l2_memory_responder_if.slave  bus
);

  localparam int AW      = $clog2(MEM_SIZE);
  localparam int WORDS   = MEM_SIZE / 4;
  localparam int IDX_W   = AW - 2;
  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESPOND
  } state_e;

  state_e            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              accept;
  logic              enter_respond;

  memory_operation_e req_type_q;
  logic [IDX_W-1:0]  req_idx_q;
  logic [XLEN-1:0]   req_data_q;

  memory_operation_e rsp_type;
  logic [IDX_W-1:0]  rsp_idx;
  logic [IDX_W-1:0]  in_idx;

  logic [XLEN-1:0]   mem [WORDS];
  logic [XLEN-1:0]   fetched_q;

  // Address bits outside the word index are ignored: addresses wrap modulo MEM_SIZE.
  assign in_idx = bus.l2_req_address[AW-1:2];
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.l2_req_address[XLEN-1:AW], bus.l2_req_address[1:0]};

  // Next state, latency counter and request-capture strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned and infers a latch.
    state_n       = state;
    cnt_n         = cnt;
    accept        = 1'b0;
    enter_respond = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.l2_req_valid) begin
          accept = 1'b1;
          cnt_n  = (bus.l2_req_type == STORE) ? CNT_W'(WRITE_LATENCY - 1)
                                              : CNT_W'(READ_LATENCY - 1);
          if (cnt_n == '0) begin
            state_n       = RESPOND;
            enter_respond = 1'b1;
          end else begin
            state_n = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_n = cnt - 1'b1;
        if (cnt_n == '0) begin
          state_n       = RESPOND;
          enter_respond = 1'b1;
        end
      end
      RESPOND: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register and latency counter; reset abandons any in-flight request.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Capture the accepted request; later input changes are ignored until completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_type_q <= LOAD;
      req_idx_q  <= '0;
      req_data_q <= '0;
    end else if (accept) begin
      req_type_q <= bus.l2_req_type;
      req_idx_q  <= in_idx;
      req_data_q <= bus.l2_word_to_store;
    end
  end

  // With a latency of 1 the request enters RESPOND straight from IDLE, before it is latched.
  always_comb begin
    rsp_type = req_type_q;
    rsp_idx  = req_idx_q;
    if (state == IDLE) begin
      rsp_type = bus.l2_req_type;
      rsp_idx  = in_idx;
    end
  end

  // Load data is registered on the edge entering RESPOND; STORE leaves it untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetched_q <= '0;
    end else if (enter_respond) begin
      if (rsp_type == LOAD) begin
        fetched_q <= mem[rsp_idx];
      end else if (rsp_type != STORE) begin
        fetched_q <= '0;
      end
    end
  end

  // Store data is committed on the edge leaving RESPOND.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset so its contents survive reset and it can map onto block RAM.
    if (state == RESPOND && req_type_q == STORE) begin
      mem[req_idx_q] <= req_data_q;
    end
  end

  assign bus.l2_fetched_word  = fetched_q;
  assign bus.l2_req_fulfilled = (state == RESPOND);
  assign bus.busy             = (state != IDLE);

endmodule

// File: tb/tb_l2_memory_responder.sv
// Randomized self-checking bench: two responders (default latencies and a
// 1/7 latency build) driven against a word-array reference model.
module tb_l2_memory_responder;
  import xentry_pkg::*;

  localparam int XLEN     = 32;
  localparam int MEM_SIZE = 4096;
  localparam int WORDS    = MEM_SIZE / 4;
  localparam int RL_A = 4, WL_A = 4;
  localparam int RL_B = 1, WL_B = 7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  l2_memory_responder_if #(.XLEN(XLEN)) bus_a ();
  l2_memory_responder_if #(.XLEN(XLEN)) bus_b ();

  l2_memory_responder #(
    .XLEN(XLEN), .MEM_SIZE(MEM_SIZE), .READ_LATENCY(RL_A), .WRITE_LATENCY(WL_A)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );

  l2_memory_responder #(
    .XLEN(XLEN), .MEM_SIZE(MEM_SIZE), .READ_LATENCY(RL_B), .WRITE_LATENCY(WL_B)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  // Reference model: one word array per responder plus the last returned word.
  logic [31:0] ref_mem   [2][WORDS];
  bit          ref_known [2][WORDS];
  logic [31:0] ref_last  [2];
  bit          ref_last_known [2];

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] last_rdata;
  int          last_lat;
  int unsigned last_fcyc;

  task automatic drive(input int w, input logic v, input memory_operation_e t,
                       input logic [31:0] a, input logic [31:0] d);
    if (w == 0) begin
      bus_a.l2_req_valid = v; bus_a.l2_req_type = t;
      bus_a.l2_req_address = a; bus_a.l2_word_to_store = d;
    end else begin
      bus_b.l2_req_valid = v; bus_b.l2_req_type = t;
      bus_b.l2_req_address = a; bus_b.l2_word_to_store = d;
    end
  endtask

  function automatic logic get_ful(input int w);
    return (w == 0) ? bus_a.l2_req_fulfilled : bus_b.l2_req_fulfilled;
  endfunction

  function automatic logic get_busy(input int w);
    return (w == 0) ? bus_a.busy : bus_b.busy;
  endfunction

  function automatic logic [31:0] get_word(input int w);
    return (w == 0) ? bus_a.l2_fetched_word : bus_b.l2_fetched_word;
  endfunction

  function automatic int lat_of(input int w, input memory_operation_e op);
    if (op == STORE) return (w == 0) ? WL_A : WL_B;
    return (w == 0) ? RL_A : RL_B;
  endfunction

  function automatic memory_operation_e other_op(input logic [1:0] raw);
    return memory_operation_e'(raw);
  endfunction

  // One complete transaction; returns at the falling edge inside the fulfilled cycle.
  task automatic issue(input int w, input memory_operation_e op, input logic [31:0] addr,
                       input logic [31:0] data, input bit perturb, input string tag);
    int          idx;
    int          exp_lat;
    logic [31:0] exp_word;
    bit          know;
    bit          got;
    idx     = int'(addr[11:2]);
    exp_lat = lat_of(w, op);
    if (op == LOAD) begin
      exp_word = ref_mem[w][idx];   know = ref_known[w][idx];
    end else if (op == STORE) begin
      exp_word = ref_last[w];       know = ref_last_known[w];
    end else begin
      exp_word = 32'h0;             know = 1'b1;
    end

    @(negedge clk);
    total_cnt++;
    if (get_ful(w) !== 1'b0 || get_busy(w) !== 1'b0)
      $display("FAIL %s idle_before: fulfilled=%b busy=%b, want 0/0", tag, get_ful(w), get_busy(w));
    else pass_cnt++;
    drive(w, 1'b1, op, addr, data);
    @(posedge clk);

    got = 1'b0;
    last_lat = 0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge clk);
      if (get_ful(w) === 1'b1) begin
        got        = 1'b1;
        last_lat   = i;
        last_fcyc  = cyc;
        last_rdata = get_word(w);
        drive(w, 1'b0, LOAD, 32'h0, 32'h0);
      end else begin
        total_cnt++;
        if (get_busy(w) !== 1'b1)
          $display("FAIL %s busy_in_flight: busy=%b at cycle +%0d, want 1", tag, get_busy(w), i);
        else pass_cnt++;
        if (perturb && i == 1) drive(w, 1'b0, LOAD, addr ^ 32'h40, ~data);
      end
    end

    total_cnt++;
    if (!got || last_lat != exp_lat)
      $display("FAIL %s latency: got %0d (seen=%0d), want %0d", tag, last_lat, got, exp_lat);
    else pass_cnt++;

    if (got && know) begin
      total_cnt++;
      if (last_rdata !== exp_word)
        $display("FAIL %s fetched_word: got %h, want %h", tag, last_rdata, exp_word);
      else pass_cnt++;
    end

    if (op == STORE) begin
      ref_mem[w][idx]   = data;
      ref_known[w][idx] = 1'b1;
    end else begin
      ref_last[w]       = exp_word;
      ref_last_known[w] = know;
    end
  endtask

  task automatic test_reset();
    drive(0, 1'b0, LOAD, 32'h0, 32'h0);
    drive(1, 1'b0, LOAD, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      total_cnt++;
      if (get_word(w) !== 32'h0 || get_ful(w) !== 1'b0 || get_busy(w) !== 1'b0)
        $display("FAIL reset_state dut%0d: word=%h ful=%b busy=%b, want 0/0/0",
                 w, get_word(w), get_ful(w), get_busy(w));
      else pass_cnt++;
      ref_last[w]       = 32'h0;
      ref_last_known[w] = 1'b1;
    end
    reset = 1'b0;
  endtask

  task automatic test_store_load();
    issue(0, STORE, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0, "store_40");
    issue(0, LOAD,  32'h0000_0040, 32'h0,         1'b0, "load_40");
  endtask

  task automatic test_wrap();
    issue(0, STORE, 32'h0000_0044, 32'h1234_5678, 1'b0, "store_44");
    issue(0, LOAD,  32'h0000_1044, 32'h0,         1'b0, "load_1044_wrap");
    issue(0, LOAD,  32'h0000_0047, 32'h0,         1'b0, "load_47_lowbits");
    issue(0, LOAD,  32'hFFFF_F044, 32'h0,         1'b0, "load_fffff044_wrap");
  endtask

  task automatic test_latency_b();
    int unsigned prev;
    issue(1, STORE, 32'h0000_0010, $urandom, 1'b0, "b_store_lat7");
    issue(1, LOAD,  32'h0000_0010, 32'h0,    1'b0, "b_load_lat1");
    prev = last_fcyc;
    for (int i = 0; i < 5; i++) begin
      issue(1, LOAD, 32'h0000_0010, 32'h0, 1'b0, "b_b2b_load");
      total_cnt++;
      if (last_fcyc - prev != 2)
        $display("FAIL b_b2b_spacing: got %0d cycles, want 2", last_fcyc - prev);
      else pass_cnt++;
      prev = last_fcyc;
    end
  endtask

  task automatic test_line_fill();
    int unsigned prev;
    for (int i = 0; i < 8; i++)
      issue(0, STORE, 32'h100 + 32'(i * 4), $urandom, 1'b0, "fill_prestore");
    for (int i = 0; i < 8; i++) begin
      issue(0, LOAD, 32'h100 + 32'(i * 4), 32'h0, 1'b0, "fill_load");
      if (i > 0) begin
        total_cnt++;
        if (last_fcyc - prev != RL_A + 1)
          $display("FAIL fill_spacing: got %0d cycles, want %0d", last_fcyc - prev, RL_A + 1);
        else pass_cnt++;
      end
      prev = last_fcyc;
    end
  endtask

  task automatic test_busy_perturb();
    issue(0, STORE, 32'h0000_01C0, 32'h0BAD_0BAD, 1'b0, "perturb_prestore");
    issue(0, STORE, 32'h0000_0180, 32'hCAFE_F00D, 1'b1, "perturb_store");
    issue(0, LOAD,  32'h0000_0180, 32'h0,         1'b0, "perturb_orig_word");
    issue(0, LOAD,  32'h0000_01C0, 32'h0,         1'b0, "perturb_other_word");
  endtask

  task automatic test_other_type();
    for (int w = 0; w < 2; w++) begin
      issue(w, STORE, 32'h0000_0300, 32'h5A5A_1234, 1'b0, "other_prestore");
      issue(w, LOAD,  32'h0000_0300, 32'h0,         1'b0, "other_preload");
      issue(w, other_op(2'b10), 32'h0000_0300, 32'hFFFF_FFFF, 1'b0, "other_op");
      issue(w, LOAD,  32'h0000_0300, 32'h0,         1'b0, "other_nowrite");
      issue(w, other_op(2'b11), 32'h0000_0300, 32'h1, 1'b0, "other_op3");
      issue(w, STORE, 32'h0000_0304, 32'h7777_7777, 1'b0, "store_keeps_word");
    end
  endtask

  task automatic test_reset_midop();
    int pulses;
    issue(0, STORE, 32'h0000_0080, 32'hAAAA_AAAA, 1'b0, "rst_prestore");
    issue(0, LOAD,  32'h0000_0084, 32'h0, 1'b0, "rst_setword");
    @(negedge clk);
    drive(0, 1'b1, STORE, 32'h0000_0080, 32'h5555_5555);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, LOAD, 32'h0, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    total_cnt++;
    if (bus_a.busy !== 1'b0 || bus_a.l2_req_fulfilled !== 1'b0 || bus_a.l2_fetched_word !== 32'h0)
      $display("FAIL reset_async: busy=%b ful=%b word=%h, want 0/0/0",
               bus_a.busy, bus_a.l2_req_fulfilled, bus_a.l2_fetched_word);
    else pass_cnt++;
    ref_last[0] = 32'h0;
    ref_last[1] = 32'h0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 2) reset = 1'b0;
      if (bus_a.l2_req_fulfilled === 1'b1) pulses++;
    end
    total_cnt++;
    if (pulses != 0) $display("FAIL reset_no_pulse: got %0d pulses, want 0", pulses);
    else pass_cnt++;
    issue(0, LOAD, 32'h0000_0080, 32'h0, 1'b0, "rst_no_write");
  endtask

  task automatic test_random();
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 16; i++)
        issue(w, STORE, 32'h200 + 32'(i * 4), $urandom, 1'b0, "rand_prefill");
    for (int n = 0; n < 60; n++) begin
      int                w;
      int                r;
      logic [31:0]       addr;
      memory_operation_e op;
      w    = n % 2;
      r    = $urandom_range(0, 9);
      addr = ($urandom & 32'hFFFF_F003) | (32'h200 + 32'($urandom_range(0, 15) * 4));
      if (r < 4)       op = LOAD;
      else if (r < 8)  op = STORE;
      else             op = other_op((r == 8) ? 2'b10 : 2'b11);
      issue(w, op, addr, $urandom, 1'b0, "rand_op");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_store_load();
    test_wrap();
    test_latency_b();
    test_line_fill();
    test_busy_perturb();
    test_other_type();
    test_reset_midop();
    test_random();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
